// File: rtl/axi_slave_write_resp_gen.sv
// AXI slave write response generator: queues accepted AW IDs with their decode
// status and pairs each with a completed W burst to drive the B channel.
module axi_slave_write_resp_gen #(
  parameter int                    Num_Of_Masters  = 2,
  parameter int                    Masters_Id_Size = (Num_Of_Masters > 1) ? $clog2(Num_Of_Masters) : 1,
  parameter int                    Addr_Width      = 32,
  parameter int                    Fifo_Depth      = 4,
  parameter logic [Addr_Width-1:0] Slave_Base      = 32'h0000_0000,
  parameter logic [Addr_Width:0]   Slave_Size      = 33'h0_0000_1000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [Masters_Id_Size-1:0] S_AXI_awid,
  input  logic [Addr_Width-1:0]      S_AXI_awaddr,
  input  logic                       S_AXI_awvalid,
  output logic                       S_AXI_awready,
  input  logic                       S_AXI_wvalid,
  input  logic                       S_AXI_wready,
  input  logic                       S_AXI_wlast,
  output logic                       W_Accept_En,
  output logic [Masters_Id_Size-1:0] S_AXI_bid,
  output logic [1:0]                 S_AXI_bresp,
  output logic                       S_AXI_bvalid,
  input  logic                       S_AXI_bready
);

  localparam int              Ptr_W    = $clog2(Fifo_Depth);
  localparam int              Cnt_W    = Ptr_W + 1;
  localparam int              Entry_W  = Masters_Id_Size + 1;
  localparam logic [Cnt_W-1:0] Full_Cnt = Cnt_W'(Fifo_Depth);
  localparam logic [Cnt_W-1:0] Zero_Cnt = {Cnt_W{1'b0}};
  localparam logic [Cnt_W-1:0] One_Cnt  = Cnt_W'(1);
  localparam logic [Ptr_W-1:0] One_Ptr  = Ptr_W'(1);

  // Out-of-window check, widened by one bit so Base+Size cannot wrap.
  function automatic logic decode_err(input logic [Addr_Width-1:0] addr);
    logic [Addr_Width:0] addr_ext;
    logic [Addr_Width:0] lo_ext;
    logic [Addr_Width:0] hi_ext;
    addr_ext = {1'b0, addr};
    lo_ext   = {1'b0, Slave_Base};
    hi_ext   = lo_ext + Slave_Size - (Addr_Width + 1)'(1);
    return (addr_ext < lo_ext) || (addr_ext > hi_ext);
  endfunction

  logic [Entry_W-1:0]         fifo_mem_r [Fifo_Depth];
  logic [Ptr_W-1:0]           wr_ptr_r;
  logic [Ptr_W-1:0]           rd_ptr_r;
  logic [Cnt_W-1:0]           count_r;
  logic [Cnt_W-1:0]           wcnt_r;
  logic                       bvalid_r;
  logic [Masters_Id_Size-1:0] bid_r;
  logic [1:0]                 bresp_r;

  logic                       push_s;
  logic                       wdone_s;
  logic                       load_s;
  logic [Entry_W-1:0]         head_s;
  logic [Cnt_W-1:0]           count_nxt_s;
  logic [Cnt_W-1:0]           wcnt_nxt_s;
  logic                       bvalid_nxt_s;
  logic [Masters_Id_Size-1:0] bid_nxt_s;
  logic [1:0]                 bresp_nxt_s;

  assign S_AXI_awready = (count_r != Full_Cnt);
  assign W_Accept_En   = (wcnt_r != Full_Cnt);
  assign S_AXI_bvalid  = bvalid_r;
  assign S_AXI_bid     = bid_r;
  assign S_AXI_bresp   = bresp_r;

  assign push_s  = S_AXI_awvalid & S_AXI_awready;
  assign wdone_s = S_AXI_wvalid & S_AXI_wready & S_AXI_wlast;
  // A held response blocks the next load until it is taken.
  assign load_s  = (count_r != Zero_Cnt) & (wcnt_r != Zero_Cnt) & (~bvalid_r | S_AXI_bready);
  assign head_s  = fifo_mem_r[rd_ptr_r];

  // AW occupancy next-state.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, load_s})
      2'b10:   count_nxt_s = count_r + One_Cnt;
      2'b01:   count_nxt_s = count_r - One_Cnt;
      default: count_nxt_s = count_r;
    endcase
  end

  // Completed-burst counter next-state.
  always_comb begin
    wcnt_nxt_s = wcnt_r;
    case ({wdone_s, load_s})
      2'b10:   wcnt_nxt_s = wcnt_r + One_Cnt;
      2'b01:   wcnt_nxt_s = wcnt_r - One_Cnt;
      default: wcnt_nxt_s = wcnt_r;
    endcase
  end

  // B channel next-state: load, retire, or hold.
  always_comb begin
    bvalid_nxt_s = bvalid_r;
    bid_nxt_s    = bid_r;
    bresp_nxt_s  = bresp_r;
    if (load_s) begin
      bvalid_nxt_s = 1'b1;
      bid_nxt_s    = head_s[Entry_W-1:1];
      bresp_nxt_s  = head_s[0] ? 2'b11 : 2'b00;
    end else if (bvalid_r && S_AXI_bready) begin
      bvalid_nxt_s = 1'b0;
    end else begin
      bvalid_nxt_s = bvalid_r;
    end
  end

  // AW FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {Ptr_W{1'b0}};
      rd_ptr_r <= {Ptr_W{1'b0}};
      for (int i = 0; i < Fifo_Depth; i++) begin
        fifo_mem_r[i] <= {Entry_W{1'b0}};
      end
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= {S_AXI_awid, decode_err(S_AXI_awaddr)};
        wr_ptr_r             <= wr_ptr_r + One_Ptr;
      end
      if (load_s) begin
        rd_ptr_r <= rd_ptr_r + One_Ptr;
      end
    end
  end

  // Counters and registered B outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r  <= Zero_Cnt;
      wcnt_r   <= Zero_Cnt;
      bvalid_r <= 1'b0;
      bid_r    <= {Masters_Id_Size{1'b0}};
      bresp_r  <= 2'b00;
    end else begin
      count_r  <= count_nxt_s;
      wcnt_r   <= wcnt_nxt_s;
      bvalid_r <= bvalid_nxt_s;
      bid_r    <= bid_nxt_s;
      bresp_r  <= bresp_nxt_s;
    end
  end

endmodule

// File: tb/tb_axi_slave_write_resp_gen.sv
// Directed bench for axi_slave_write_resp_gen: expected B responses are queued
// at stimulus time and checked by an independent monitor on each handshake.
module tb_axi_slave_write_resp_gen;

  logic        clk;
  logic        rst;
  logic [0:0]  awid;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic        wvalid;
  logic        wready;
  logic        wlast;
  logic        w_accept_en;
  logic [0:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int n_cmp = 0;
  int n_err = 0;
  logic [2:0] exp_q [$];
  logic seen_b;

  axi_slave_write_resp_gen dut (
    .clk           (clk),
    .rst           (rst),
    .S_AXI_awid    (awid),
    .S_AXI_awaddr  (awaddr),
    .S_AXI_awvalid (awvalid),
    .S_AXI_awready (awready),
    .S_AXI_wvalid  (wvalid),
    .S_AXI_wready  (wready),
    .S_AXI_wlast   (wlast),
    .W_Accept_En   (w_accept_en),
    .S_AXI_bid     (bid),
    .S_AXI_bresp   (bresp),
    .S_AXI_bvalid  (bvalid),
    .S_AXI_bready  (bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [0:0] id, input logic [31:0] addr, input logic wl);
    awvalid = av;
    awid    = id;
    awaddr  = addr;
    wvalid  = wl;
    wready  = wl;
    wlast   = wl;
  endtask

  // Scoreboard monitor: every B handshake pops and compares one expectation.
  always @(negedge clk) begin
    if (rst && bvalid && bready) begin
      seen_b = 1'b1;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_b: got bid=%0h bresp=%0h with nothing expected", bid, bresp);
      end else begin
        check("b_resp", {29'd0, bid, bresp}, {29'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bready = 1'b1;
    seen_b = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    check("rst_awready", awready, 1);
    check("rst_wacc", w_accept_en, 1);
    #20;
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("reset_bvalid", bvalid, 0);
    check("reset_bid", bid, 0);
    check("reset_bresp", bresp, 0);

    // Single write, AW and WLAST together: response two cycles later.
    tick();
    drive(1'b1, 1'b1, 32'h10, 1'b1);
    exp_q.push_back({1'b1, 2'b00});
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("single_n1_bvalid", bvalid, 0);
    tick();
    @(negedge clk);
    check("single_n2_bvalid", bvalid, 1);
    check("single_n2_bid", bid, 1);
    tick();
    @(negedge clk);
    check("single_n3_bvalid", bvalid, 0);

    // Decode error above the window, then the last in-window byte.
    tick();
    drive(1'b1, 1'b0, 32'h2000, 1'b1);
    exp_q.push_back({1'b0, 2'b11});
    tick();
    drive(1'b1, 1'b1, 32'hFFF, 1'b1);
    exp_q.push_back({1'b1, 2'b00});
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("decerr_bresp", bresp, 2'b11);
    check("decerr_bid", bid, 0);
    tick();
    @(negedge clk);
    check("fff_bresp", bresp, 2'b00);
    check("fff_bid", bid, 1);
    repeat (2) tick();

    // Backpressure: first response must hold for five cycles.
    bready = 1'b0;
    drive(1'b1, 1'b0, 32'h20, 1'b1);
    exp_q.push_back({1'b0, 2'b00});
    tick();
    drive(1'b1, 1'b1, 32'h24, 1'b1);
    exp_q.push_back({1'b1, 2'b00});
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", {bvalid, bid, bresp}, {1'b1, 1'b0, 2'b00});
      tick();
    end
    bready = 1'b1;
    @(negedge clk);
    check("bp_release_bid", bid, 0);
    tick();
    @(negedge clk);
    check("bp_next_bvalid", bvalid, 1);
    check("bp_next_bid", bid, 1);
    tick();
    @(negedge clk);
    check("bp_drained", bvalid, 0);

    // FIFO full: four AWs without W data.
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'(i), 32'h30 + 32'(i), 1'b0);
      exp_q.push_back({1'(i), 2'b00});
      tick();
    end
    drive(1'b1, 1'b0, 32'h40, 1'b0);
    exp_q.push_back({1'b0, 2'b00});
    @(negedge clk);
    check("full_awready", awready, 0);
    tick();
    @(negedge clk);
    check("full_stall_awready", awready, 0);
    tick();
    wvalid = 1'b1; wready = 1'b1; wlast = 1'b1;
    tick();
    wvalid = 1'b0; wready = 1'b0; wlast = 1'b0;
    tick();
    @(negedge clk);
    check("full_awready_back", awready, 1);
    tick();
    awvalid = 1'b0;
    @(negedge clk);
    check("full_again", awready, 0);
    wvalid = 1'b1; wready = 1'b1; wlast = 1'b1;
    repeat (4) tick();
    wvalid = 1'b0; wready = 1'b0; wlast = 1'b0;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    check("full_drain_left", exp_q.size(), 0);
    repeat (2) tick();

    // W-first: four completed bursts with no address.
    wvalid = 1'b1; wready = 1'b1; wlast = 1'b1;
    repeat (4) tick();
    wvalid = 1'b0; wready = 1'b0; wlast = 1'b0;
    @(negedge clk);
    check("wfirst_wacc_low", w_accept_en, 0);
    tick();
    drive(1'b1, 1'b1, 32'h50, 1'b0);
    exp_q.push_back({1'b1, 2'b00});
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("wfirst_n1", {bvalid, w_accept_en}, {1'b0, 1'b0});
    tick();
    @(negedge clk);
    check("wfirst_n2", {bvalid, bid, w_accept_en}, {1'b1, 1'b1, 1'b1});
    repeat (2) tick();

    // Reset mid-flight with a held response and a pending entry.
    bready = 1'b0;
    drive(1'b1, 1'b0, 32'h60, 1'b0);
    tick();
    drive(1'b1, 1'b1, 32'h64, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    @(negedge clk);
    check("mid_bvalid_held", bvalid, 1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_bvalid", bvalid, 0);
    check("mid_rst_awready", awready, 1);
    check("mid_rst_wacc", w_accept_en, 1);
    tick();
    rst = 1'b1;
    bready = 1'b1;
    seen_b = 1'b0;
    repeat (10) tick();
    check("mid_no_resp", seen_b, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
